// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and pending-write scoreboard
//
// Purpose:
//   Register file placed between decode (read ports) and writeback (write
//   ports). It has two prioritised write ports, zero-latency reads with
//   same-cycle write bypass, and an optional hardwired zero register. It
//   also keeps a per-register pending-producer scoreboard and a registered
//   count of pending registers for the hazard unit.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset; clears storage and scoreboard
//   rd_addr_i    NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o    NUM_RD packed read data, same packing
//   rd_pend_o    per read port: addressed register still awaits its producer
//   we0_i/wa0_i/wd0_i   write port 0 (writeback)
//   we1_i/wa1_i/wd1_i   write port 1 (late writer; wins on an address collision)
//   pend_set_i/pend_addr_i  mark a register pending at instruction issue
//   pend_cnt_o   number of registers currently pending (0..2**ADDR_W)

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pend_o,
  input  logic                     we0_i,
  input  logic [ADDR_W-1:0]        wa0_i,
  input  logic [DATA_W-1:0]        wd0_i,
  input  logic                     we1_i,
  input  logic [ADDR_W-1:0]        wa1_i,
  input  logic [DATA_W-1:0]        wd1_i,
  input  logic                     pend_set_i,
  input  logic [ADDR_W-1:0]        pend_addr_i,
  output logic [ADDR_W:0]          pend_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_next;
  logic [ADDR_W:0]   pend_cnt_next;

  // Storage. Port 1 is checked first so it wins a same-address collision.
  // The zero register is never written, so it stays at its reset value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG != 0 && i == 0)) begin
          if (we1_i && wa1_i == ADDR_W'(i)) begin
            mem[i] <= wd1_i;
          end else if (we0_i && wa0_i == ADDR_W'(i)) begin
            mem[i] <= wd0_i;
          end
        end
      end
    end
  end

  // Next-state scoreboard: a new producer (set) outranks a retiring one
  // (write) on the same register, so the bit stays pending.
  always_comb begin
    pend_next = '0;
    for (int a = 0; a < DEPTH; a++) begin
      pend_next[a] = (pend_set_i && pend_addr_i == ADDR_W'(a))
                   | (pend[a] & ~((we0_i && wa0_i == ADDR_W'(a))
                                | (we1_i && wa1_i == ADDR_W'(a))));
    end
    if (ZERO_REG != 0) begin
      pend_next[0] = 1'b0;
    end
  end

  // Population count of the next state, so the count is exact on every
  // edge and cannot drift or wrap the way an up/down counter could.
  always_comb begin
    pend_cnt_next = '0;
    for (int a = 0; a < DEPTH; a++) begin
      pend_cnt_next = pend_cnt_next + {{ADDR_W{1'b0}}, pend_next[a]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend       <= '0;
      pend_cnt_o <= '0;
    end else begin
      pend       <= pend_next;
      pend_cnt_o <= pend_cnt_next;
    end
  end

  // Read ports. Bypass is gated by reset so every port reads 0 while the
  // file is held in reset, even when a write is being presented.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit0;
    logic              hit1;
    logic              hit_set;

    assign addr    = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign hit0    = rst_n_i && we0_i && (wa0_i == addr);
    assign hit1    = rst_n_i && we1_i && (wa1_i == addr);
    assign hit_set = pend_set_i && (pend_addr_i == addr);

    always_comb begin
      rd_data_o[k*DATA_W +: DATA_W] = mem[addr];
      if (ZERO_REG != 0 && addr == '0) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
      end else if (hit1) begin
        rd_data_o[k*DATA_W +: DATA_W] = wd1_i;
      end else if (hit0) begin
        rd_data_o[k*DATA_W +: DATA_W] = wd0_i;
      end
    end

    // A same-cycle write is bypassed, so it clears the hazard unless the
    // same register is re-claimed by a new producer in that cycle.
    assign rd_pend_o[k] = pend[addr] & ~((hit0 | hit1) & ~hit_set);
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write/two-read CPU register file.
- Sits between the ID stage (read ports) and the WB stage (write ports).
- Adds:
  - configurable data width, depth and read-port count
  - two write ports with fixed priority
  - write-to-read bypass
  - optional hardwired zero register
  - async reset clear
  - per-register pending-write scoreboard for the hazard unit

Parameters:
- DATA_W, 32: width of each register.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 always reads 0; writes to it and pending-sets on it are ignored.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- rd_addr_i  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data_o  output  NUM_RD*DATA_W  read data, same packing.
- rd_pend_o  output  NUM_RD  1 = addressed register has an outstanding producer.
- we0_i  input  1  write enable, port 0 (WB).
- wa0_i  input  ADDR_W  write address, port 0.
- wd0_i  input  DATA_W  write data, port 0.
- we1_i  input  1  write enable, port 1 (secondary/late writer).
- wa1_i  input  ADDR_W  write address, port 1.
- wd1_i  input  DATA_W  write data, port 1.
- pend_set_i  input  1  mark register pend_addr_i pending (issue of a writing instruction).
- pend_addr_i  input  ADDR_W  register to mark pending.
- pend_cnt_o  output  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - all registers cleared to 0; all pending bits cleared.
  - pend_cnt_o = 0; rd_data_o = 0 for every port; rd_pend_o = 0.
  - Reset asserted mid-write discards that write.
  - Release is synchronous to the next edge; no state change while low.
- Write:
  - On posedge with weN_i = 1, register[waN_i] <= wdN_i.
  - Both ports enabled, same address: port 1 wins, port 0 dropped.
  - Different addresses: both written.
  - Address 0 with ZERO_REG = 1: no effect.
- Read:
  - Combinational, zero latency.
  - Bypass priority per port: ZERO_REG and address 0 -> 0; else we1_i and wa1_i match -> wd1_i; else we0_i and wa0_i match -> wd0_i; else stored value.
  - A write is therefore visible the same cycle it is presented, and from storage thereafter.
- Scoreboard:
  - pend[a] is set on posedge when pend_set_i = 1 and a = pend_addr_i.
  - pend[a] is cleared on posedge when any enabled write targets a.
  - Same cycle clear and set of the same a: set wins (new producer supersedes); pend stays 1.
  - rd_pend_o[k] = pend[rd_addr k] AND NOT (same-cycle write to that address AND no same-cycle set to it). The write is bypassed, so there is no hazard unless it is immediately re-claimed.
  - pend_set_i to an already-pending register: stays 1; count unchanged.
  - Register 0 is never pending when ZERO_REG = 1.
- pend_cnt_o:
  - Registered population count of pend, updated the same edge as pend.
  - Range 0..2**ADDR_W; must not wrap.
  - Computed as the popcount of next-state pend, not by increment/decrement.
- No X propagation: uninitialised reads are impossible after reset.
- Read addresses out of range cannot occur (full decode).

Test Plan:
- Reset check: assert rst_n_i low mid-cycle while we0_i = 1, wa0_i = 3, wd0_i = 0xDEADBEEF; release; read addr 3 -> 0, pend_cnt_o = 0, all rd_pend_o = 0.
- Bypass:
  - Cycle N: we0_i = 1, wa0_i = 5, wd0_i = 0x12345678, rd_addr port0 = 5 -> rd_data port0 = 0x12345678 in cycle N.
  - Cycle N+1, write deasserted -> still 0x12345678 from storage.
- Port collision: we0_i = we1_i = 1, both address 7, wd0_i = 0xAAAA0000, wd1_i = 0x0000BBBB -> same-cycle read 0x0000BBBB; next cycle stored 0x0000BBBB.
- Zero register:
  - Write 0xFFFFFFFF to address 0 -> read 0.
  - pend_set_i on address 0 -> rd_pend_o 0, pend_cnt_o 0.
- Scoreboard:
  - Set pending on 4 and 9 -> pend_cnt_o = 2; read 4 -> rd_pend_o = 1.
  - WB write to 4 -> same-cycle rd_pend_o = 0; next cycle pend_cnt_o = 1.
  - Write and set of 9 in the same cycle -> 9 stays pending, pend_cnt_o = 1.
- Full scoreboard: set all 31 non-zero registers over 31 cycles -> pend_cnt_o = 31.
  - Set 31 again -> stays 31.
  - Dual write clearing 1 and 2 -> 29.
